// File: rtl/ram_byte_sequencer.sv
// ram_byte_sequencer: turns one byte/half/word/block read or byte/half/word
// write request into a run of single-byte accesses on the 8-bit RAM/IO bus.
// Copes with the one-cycle RAM read latency, rdy_in freezes, read flushes and
// (optionally) UART back-pressure on IO writes.
//
// Optional feature: define RAM_SEQ_IO_STALL_EN to hold IO writes
// (addr[17:16] == 2'b11) while io_buffer_full is high.
//
// Request handshake: a request transfers on a rising clk_in edge where
// req_valid && req_ready; req_ready is high only in IDLE with flush low, and
// the requester must hold its request fields stable while req_valid is high.
module ram_byte_sequencer #(
  parameter int BLOCK_WIDTH = 2,
  parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_len,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  input  logic                    flush,
  output logic                    resp_valid,
  output logic [32*BLOCK_SIZE-1:0] resp_data,
  output logic                    busy,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  output logic [1:0]              state_dbg
);

  // Pointer width: must hold the value 4*BLOCK_SIZE itself (iss == n).
  localparam int CW = $clog2(4 * BLOCK_SIZE) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [CW-1:0]   n_q;
  logic [CW-1:0]   iss_q;
  logic [CW-1:0]   cap_q;
  logic            cap_vld_q;
  logic            accept;
  logic            io_stall;
  logic            rd_issue;
  logic            wr_issue;
  logic            capture;
  logic [CW-1:0]   n_req;

`ifdef RAM_SEQ_IO_STALL_EN
  // IO window writes wait while the UART transmit buffer is full.
  assign io_stall = (state_q == S_WRITE) && (addr_q[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  assign req_ready = (state_q == S_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

  // A bus access happens only while not frozen; capture relies on the
  // previous cycle having issued an address (cap_vld_q).
  assign rd_issue = (state_q == S_READ) && rdy_in && (iss_q < n_q);
  assign wr_issue = (state_q == S_WRITE) && rdy_in && !io_stall;
  assign capture  = (state_q == S_READ) && rdy_in && cap_vld_q && !flush;

  // Byte count of an incoming request; a "block" write is a word write.
  always_comb begin
    n_req = CW'(1);
    case (req_len)
      2'd0: n_req = CW'(1);
      2'd1: n_req = CW'(2);
      2'd2: n_req = CW'(4);
      default: n_req = req_write ? CW'(4) : CW'(4 * BLOCK_SIZE);
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = req_write ? S_WRITE : S_READ;
      end
      S_READ: begin
        // Flush wins even during a freeze so a one-cycle flush is never lost.
        if (flush) state_d = S_IDLE;
        else if (capture && (cap_q == n_q - CW'(1))) state_d = S_IDLE;
      end
      S_WRITE: begin
        if (wr_issue && (iss_q == n_q - CW'(1))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs; reset gates the bus so a pending write byte is not issued
  // in the reset cycle.
  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    if (!rst_in && rd_issue) begin
      mem_a = addr_q + 32'(iss_q);
    end
    if (!rst_in && wr_issue) begin
      mem_a    = addr_q + 32'(iss_q);
      mem_dout = wdata_q[8*iss_q[1:0] +: 8];
      mem_wr   = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request latch, issue/capture pointers and the response registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      n_q        <= '0;
      iss_q      <= '0;
      cap_q      <= '0;
      cap_vld_q  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        n_q       <= n_req;
        iss_q     <= '0;
        cap_q     <= '0;
        cap_vld_q <= 1'b0;
        resp_data <= '0;
      end else if (state_q == S_READ) begin
        if (!rdy_in) begin
          // The in-flight address is lost; restart from the first missing byte.
          iss_q     <= cap_q;
          cap_vld_q <= 1'b0;
        end else begin
          if (rd_issue) iss_q <= iss_q + CW'(1);
          cap_vld_q <= rd_issue;
          if (capture) begin
            resp_data[8*cap_q +: 8] <= mem_din;
            cap_q <= cap_q + CW'(1);
            if (cap_q == n_q - CW'(1)) resp_valid <= 1'b1;
          end
        end
      end else if (state_q == S_WRITE) begin
        if (wr_issue) begin
          iss_q <= iss_q + CW'(1);
          if (iss_q == n_q - CW'(1)) resp_valid <= 1'b1;
        end
      end
    end
  end

endmodule
